// File: rtl/alu_mc.sv
// Multi-cycle ALU: one-cycle logic/arith/shift ops, iterative MUL and MOD.
// Valid/ready front end; results and flags held until the next completion.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] outalu,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             dz
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q;
  logic             is_mod_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] outalu_q;
  logic             zero_q;
  logic             carry_q;
  logic             ovf_q;
  logic             dz_q;

  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   diff_d;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;
  logic             long_op;

  logic [WIDTH-1:0] acc_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] fin_d;
  logic             last;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign outalu    = outalu_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

  // MUL always iterates; MOD iterates only for a non-zero divisor
  assign long_op = (select == 3'b110) ||
                   ((select == 3'b111) && (b != '0));

  // Single-cycle result; MOD-by-zero falls through to the all-ones default
  always_comb begin
    sum_d   = {1'b0, a} + {1'b0, b};
    diff_d  = {1'b0, a} - {1'b0, b};
    res_d   = '1;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (select)
      3'b000: begin
        res_d   = sum_d[WIDTH-1:0];
        carry_d = sum_d[WIDTH];
        ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) &&
                  (sum_d[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        res_d   = diff_d[WIDTH-1:0];
        carry_d = diff_d[WIDTH];
        ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) &&
                  (diff_d[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010:  res_d = a & b;
      3'b011:  res_d = a | b;
      3'b100:  res_d = a << b;
      3'b101:  res_d = a >> b;
      default: res_d = '1;
    endcase
  end

  // One shift-add or restoring-division step per RUN cycle
  always_comb begin
    acc_d  = b_q[0] ? (acc_q + a_q) : acc_q;
    rem_sh = {rem_q[WIDTH-1:0], a_q[WIDTH-1]};
    rem_d  = rem_sh;
    if (rem_sh >= {1'b0, b_q}) begin
      rem_d = rem_sh - {1'b0, b_q};
    end
    fin_d = is_mod_q ? rem_d[WIDTH-1:0] : acc_d;
    last  = (cnt_q == LAST);
  end

  // Control FSM with registered result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      is_mod_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      outalu_q    <= '0;
      zero_q      <= 1'b1;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (long_op) begin
              is_mod_q <= select[0];
              a_q      <= a;
              b_q      <= b;
              acc_q    <= '0;
              rem_q    <= '0;
              cnt_q    <= '0;
              state_q  <= RUN;
            end else begin
              outalu_q    <= res_d;
              zero_q      <= (res_d == '0);
              carry_q     <= carry_d;
              ovf_q       <= ovf_d;
              dz_q        <= (select == 3'b111);
              out_valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          a_q   <= a_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (is_mod_q) begin
            rem_q <= rem_d;
          end else begin
            acc_q <= acc_d;
            b_q   <= b_q >> 1;
          end
          if (last) begin
            outalu_q    <= fin_d;
            zero_q      <= (fin_d == '0);
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
